// File: rtl/ram2x8_fifo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ram2x8_fifo_ctrl_pkg
//   Shared definitions for the ram2x8 FIFO controller and the RAM it drives:
//   controller state codes and the default data/address widths.
// ---------------------------------------------------------------------------
package ram2x8_fifo_ctrl_pkg;

  // Controller states (kept as plain constants for legacy tool flows)
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;

  // Default geometry of the ram2x8 macro
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 1;

endpackage : ram2x8_fifo_ctrl_pkg

// File: rtl/ram2x8.sv
// ---------------------------------------------------------------------------
// ram2x8
//   Small single-port RAM (2 x 8 by default) with synchronous write,
//   synchronous clear/preset and a combinational read port.
// Ports
//   clk      in   rising-edge clock
//   we       in   write enable
//   address  in   shared read/write address
//   din      in   write data
//   clear    in   set every word to 0 (wins over preset and write)
//   preset   in   set every word to all ones (wins over write)
//   dout     out  combinational read of the addressed word
// ---------------------------------------------------------------------------
module ram2x8
  import ram2x8_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] din,
  input  logic              clear,
  input  logic              preset,
  output logic [DATA_W-1:0] dout
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      r_mem <= '{default: '0};
    end else if (preset) begin
      r_mem <= '{default: '1};
    end else if (we) begin
      r_mem[address] <= din;
    end
  end

  assign dout = r_mem[address];

endmodule : ram2x8

// File: rtl/ram2x8_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ram2x8_fifo_ctrl
//   Ready/valid FIFO built around an external single-port RAM (ram2x8).
//   The RAM holds up to 2**ADDR_W words; a one-entry output register holds
//   the FIFO head, so total capacity is 2**ADDR_W + 1. The single RAM address
//   port is shared cycle by cycle between writes (push) and reads (fetch into
//   the output register); fetch has priority.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous flush, drops all stored data
//   in_valid/in_data    producer side, in_ready when accepted
//   out_valid/out_data  registered FIFO head, taken when out_ready
//   count               occupancy (RAM entries + output register)
//   ram_we/ram_address/ram_din/ram_clear/ram_preset   RAM controls
//   ram_dout            combinational RAM read data
// ---------------------------------------------------------------------------
module ram2x8_fifo_ctrl
  import ram2x8_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W+1:0] count,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_clear,
  output logic              ram_preset,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2**ADDR_W);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_ram_cnt;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;

  logic w_run;
  logic w_fetch;
  logic w_push;
  logic w_pop;

  assign w_run = (r_state == ST_RUN);

  // Refill the output register whenever it is empty or being drained.
  // A flush in the same cycle discards it in the sequential block.
  assign w_fetch = w_run && (r_ram_cnt != '0) && (!r_out_valid || out_ready);

  // Writes only get the RAM port when no fetch needs it.
  assign in_ready = w_run && !flush && (r_ram_cnt < DEPTH_C) && !w_fetch;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = r_out_valid && out_ready && !w_fetch;

  assign ram_we      = w_push;
  assign ram_address = w_push ? r_wr_ptr : r_rd_ptr;
  assign ram_din     = in_data;
  assign ram_clear   = (r_state == ST_INIT);
  assign ram_preset  = 1'b0;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign count     = {1'b0, r_ram_cnt} + {{(ADDR_W+1){1'b0}}, r_out_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ram_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (r_state == ST_INIT) begin
      // One cycle with ram_clear asserted wipes the RAM, then run.
      r_state <= ST_RUN;
    end else if (flush) begin
      // out_data keeps its last value; only control state is dropped.
      r_state     <= ST_INIT;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ram_cnt   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      // Push and fetch are mutually exclusive, so ram_cnt moves by at most one.
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_ram_cnt <= r_ram_cnt + 1'b1;
      end
      if (w_fetch) begin
        r_out_data  <= ram_dout;
        r_out_valid <= 1'b1;
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_ram_cnt   <= r_ram_cnt - 1'b1;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule : ram2x8_fifo_ctrl

// File: tb/tb_ram2x8_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ram2x8_fifo_ctrl
//   Controller plus ram2x8 wired back to back, compared each cycle against a
//   queue-based model of the FIFO behaviour.
// ---------------------------------------------------------------------------
module tb_ram2x8_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] count;
  logic       ram_we;
  logic [0:0] ram_address;
  logic [7:0] ram_din;
  logic       ram_clear;
  logic       ram_preset;
  logic [7:0] ram_dout;

  always #5 clk = ~clk;

  ram2x8_fifo_ctrl #(.DATA_W(8), .ADDR_W(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .ram_we(ram_we), .ram_address(ram_address),
    .ram_din(ram_din), .ram_clear(ram_clear), .ram_preset(ram_preset),
    .ram_dout(ram_dout)
  );

  ram2x8 #(.DATA_W(8), .ADDR_W(1)) u_ram (
    .clk(clk), .we(ram_we), .address(ram_address), .din(ram_din),
    .clear(ram_clear), .preset(ram_preset), .dout(ram_dout)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: words sitting in the RAM, the output register,
  // and how many words have been written/read since the last flush.
  bit         m_init;
  logic [7:0] ram_q[$];
  bit         m_ov;
  logic [7:0] m_od;
  int         m_wr;
  int         m_rd;
  bit         e_fetch;
  bit         e_ready;
  bit         e_push;

  logic [7:0] src_q[$];   // words waiting to be offered
  logic [7:0] got_q[$];   // words observed leaving the FIFO

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_init = 1'b1;
    ram_q.delete();
    m_ov = 1'b0;
    m_od = 8'h00;
    m_wr = 0;
    m_rd = 0;
  endtask

  // One clock cycle: check the combinational/registered outputs against the
  // model with the inputs already applied, clock, then advance the model.
  task automatic step();
    logic [31:0] exp_addr;
    #1;
    e_fetch  = !m_init && (ram_q.size() != 0) && (!m_ov || out_ready);
    e_ready  = !m_init && !flush && (ram_q.size() < 2) && !e_fetch;
    e_push   = in_valid && e_ready;
    exp_addr = e_push ? 32'(m_wr % 2) : 32'(m_rd % 2);
    chk("in_ready",    32'(in_ready),    32'(e_ready));
    chk("out_valid",   32'(out_valid),   32'(m_ov));
    chk("out_data",    32'(out_data),    32'(m_od));
    chk("count",       32'(count),       32'(ram_q.size()) + 32'(m_ov));
    chk("ram_we",      32'(ram_we),      32'(e_push));
    chk("ram_address", 32'(ram_address), exp_addr);
    chk("ram_clear",   32'(ram_clear),   32'(m_init));
    chk("ram_preset",  32'(ram_preset),  32'h0);
    chk("ram_din",     32'(ram_din),     32'(in_data));
    if (!m_init && !flush && m_ov && out_ready) got_q.push_back(out_data);
    @(posedge clk);
    #1;
    if (m_init) begin
      m_init = 1'b0;
    end else if (flush) begin
      m_init = 1'b1;
      ram_q.delete();
      m_ov = 1'b0;
      m_wr = 0;
      m_rd = 0;
    end else begin
      if (e_push) begin
        ram_q.push_back(in_data);
        m_wr++;
      end
      if (e_fetch) begin
        m_od = ram_q.pop_front();
        m_ov = 1'b1;
        m_rd++;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
    end
  endtask

  // Offer the head of src_q (if any) for one cycle.
  task automatic drive_cycle();
    in_valid = (src_q.size() != 0);
    if (src_q.size() != 0) in_data = src_q[0];
    step();
    if (e_push) void'(src_q.pop_front());
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),    32'h0);
    chk({tag, "_ram_we"},    32'(ram_we),      32'h0);
    chk({tag, "_address"},   32'(ram_address), 32'h0);
    chk({tag, "_count"},     32'(count),       32'h0);
    chk({tag, "_ram_clear"}, 32'(ram_clear),   32'h1);
    chk({tag, "_out_valid"}, 32'(out_valid),   32'h0);
    chk({tag, "_out_data"},  32'(out_data),    32'h0);
  endtask

  initial begin
    int budget;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    model_reset();

    // Reset and init
    #2;
    check_reset_values("rst");
    #10;
    rst_n = 1'b1;
    step();                       // INIT edge
    #1;
    chk("init_in_ready", 32'(in_ready), 32'h1);
    chk("init_count",    32'(count),    32'h0);

    // Single word with out_ready=1
    out_ready = 1'b1;
    src_q = '{8'hA5};
    chk("single_addr0", 32'(ram_address), 32'h0);
    drive_cycle();                // push edge
    in_valid = 1'b0;
    step();                       // fetch edge
    chk("single_valid", 32'(out_valid), 32'h1);
    chk("single_data",  32'(out_data),  32'hA5);
    step();                       // pop

    // Fill with the consumer stalled
    out_ready = 1'b0;
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 8; i++) drive_cycle();
    chk("fill_count",    32'(count),        32'h3);
    chk("fill_in_ready", 32'(in_ready),     32'h0);
    chk("fill_head",     32'(out_data),     32'h11);
    chk("fill_pending",  32'(src_q.size()), 32'h1);

    // Drain in order
    src_q.delete();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 4; i++) step();
    chk("drain_len", 32'(got_q.size()), 32'h3);
    if (got_q.size() == 3) begin
      chk("drain_0", 32'(got_q[0]), 32'h11);
      chk("drain_1", 32'(got_q[1]), 32'h22);
      chk("drain_2", 32'(got_q[2]), 32'h33);
    end
    chk("drain_wrap_addr", 32'(ram_address), 32'h0);

    // Streaming 00..0F
    got_q.delete();
    for (int i = 0; i < 16; i++) src_q.push_back(8'(i));
    budget = 0;
    while ((src_q.size() != 0 || ram_q.size() != 0 || m_ov) && budget < 100) begin
      drive_cycle();
      budget++;
    end
    chk("stream_timeout", 32'(budget < 100), 32'h1);
    chk("stream_len", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < got_q.size() && i < 16; i++)
      chk($sformatf("stream_%0d", i), 32'(got_q[i]), 32'(i));

    // Flush with three words stored
    out_ready = 1'b0;
    src_q = '{8'h5A, 8'h6B, 8'h7C};
    budget = 0;
    while (src_q.size() != 0 && budget < 20) begin
      drive_cycle();
      budget++;
    end
    in_valid = 1'b0;
    step();
    chk("pre_flush_count", 32'(count), 32'h3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_clear", 32'(ram_clear), 32'h1);
    chk("flush_count", 32'(count),     32'h0);
    step();                       // back to RUN

    // Asynchronous reset between clock edges
    src_q = '{8'hC3};
    drive_cycle();
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();                       // INIT edge

    // Randomized traffic with occasional flushes
    got_q.delete();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 31) == 0);
      step();
    end
    flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_ram2x8_fifo_ctrl
